// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer and its
// single-bit shifter datapath.
package shift_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_kind_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_e;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  localparam int MAX_STEPS = 33;

  // Single-bit steps needed to realise a shift; amounts past 33 saturate
  // because further steps cannot change data or carry.
  function automatic logic [5:0] step_count(input shift_kind_e kind, input logic [31:0] amt);
    logic [5:0] steps;
    logic [4:0] amt_m1;
    amt_m1 = amt[4:0] - 5'd1;
    if (kind == ROR) begin
      if (amt == 32'd0) begin
        steps = 6'd0;
      end else begin
        steps = {1'b0, amt_m1} + 6'd1;
      end
    end else if (amt > 32'(MAX_STEPS)) begin
      steps = 6'(MAX_STEPS);
    end else begin
      steps = amt[5:0];
    end
    return steps;
  endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-bit shifter datapath: pass, or shift one place left/right/arithmetic.
module shifter
  import shift_pkg::*;
(
  input  logic [31:0] shift_in,
  input  logic [1:0]  shift_op,
  output logic [31:0] shift_out
);

  // One-position shift selected by op code
  always_comb begin
    shift_out = shift_in;
    case (shift_op)
      SH_PASS: shift_out = shift_in;
      SH_LSL1: shift_out = {shift_in[30:0], 1'b0};
      SH_LSR1: shift_out = {1'b0, shift_in[31:1]};
      SH_ASR1: shift_out = {shift_in[31], shift_in[31:1]};
      default: shift_out = shift_in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-shift controller: drives the single-bit shifter once per
// cycle and returns result plus ARM-style carry-out over valid/ready.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [AMT_W-1:0] req_amt,
  input  logic [31:0]      req_data,
  input  logic             req_carry_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_carry,
  output logic             busy
);

  seq_state_e  state_r;
  seq_state_e  state_s;
  shift_kind_e kind_r;
  logic [5:0]  count_r;
  logic [31:0] data_r;
  logic        carry_r;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic        busy_r;

  logic [5:0]  req_steps_s;
  logic [1:0]  shift_op_s;
  logic [31:0] shift_out_s;
  logic [31:0] step_data_s;
  logic        step_carry_s;

  assign req_steps_s = step_count(shift_kind_e'(req_kind), 32'(req_amt));

  shifter u_shifter (
    .shift_in  (data_r),
    .shift_op  (shift_op_s),
    .shift_out (shift_out_s)
  );

  // Shifter op select; ROR is a logical right step with bit31 patched below
  always_comb begin
    shift_op_s = SH_PASS;
    if (state_r == SHIFT) begin
      case (kind_r)
        LSL:     shift_op_s = SH_LSL1;
        LSR:     shift_op_s = SH_LSR1;
        ASR:     shift_op_s = SH_ASR1;
        ROR:     shift_op_s = SH_LSR1;
        default: shift_op_s = SH_PASS;
      endcase
    end else begin
      shift_op_s = SH_PASS;
    end
  end

  // Next data/carry for one step
  always_comb begin
    step_data_s  = shift_out_s;
    step_carry_s = data_r[0];
    if (kind_r == ROR) begin
      step_data_s[31] = data_r[0];
    end else begin
      step_data_s[31] = shift_out_s[31];
    end
    if (kind_r == LSL) begin
      step_carry_s = data_r[31];
    end else begin
      step_carry_s = data_r[0];
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = (req_steps_s == 6'd0) ? DONE : SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (count_r == 6'd1) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      kind_r       <= LSL;
      count_r      <= 6'd0;
      data_r       <= 32'd0;
      carry_r      <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == IDLE);
      resp_valid_r <= (state_s == DONE);
      busy_r       <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            kind_r  <= shift_kind_e'(req_kind);
            data_r  <= req_data;
            carry_r <= req_carry_in;
            count_r <= req_steps_s;
          end
        end
        SHIFT: begin
          data_r  <= step_data_s;
          carry_r <= step_carry_s;
          count_r <= count_r - 6'd1;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign busy       = busy_r;
  assign resp_data  = data_r;
  assign resp_carry = carry_r;

endmodule
